// File: rtl/touch_event_decoder.sv
// Capacitive touch front end: per-sensor baseline calibration, threshold + debounce,
// and a small press/release event FIFO drained by the processor with a valid/ack handshake.
module touch_event_decoder #(
    parameter int NUM_SENSORS = 9,
    parameter int READING_W   = 32,
    parameter int THRESH      = 1000,
    parameter int DEBOUNCE    = 3,
    parameter int CAL_LOG2    = 2,
    parameter int EVQ_DEPTH   = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_SENSORS*READING_W-1:0] readings,
    input  logic                             readings_valid,
    input  logic                             recalibrate,
    input  logic                             event_ack,
    output logic                             event_valid,
    output logic [$clog2(NUM_SENSORS)-1:0]   event_sensor,
    output logic                             event_press,
    output logic [NUM_SENSORS-1:0]           touch_mask,
    output logic                             calibrated,
    output logic                             overflow,
    output logic                             busy
);

    localparam int IDX_W = $clog2(NUM_SENSORS);
    localparam int ACC_W = READING_W + CAL_LOG2;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam int Q_W   = $clog2(EVQ_DEPTH);
    localparam int PTR_W = Q_W + 1;
    localparam int SWP_W = CAL_LOG2 + 1;

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_SENSORS - 1);
    localparam logic [SWP_W-1:0]   LAST_SWEEP = SWP_W'((1 << CAL_LOG2) - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic [READING_W:0] THRESH_X   = (READING_W + 1)'(THRESH);

    typedef enum logic [1:0] {CAL_IDLE, CAL_SCAN, IDLE, SCAN} state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [SWP_W-1:0]     cal_sweep;
    logic                 recal_pend;
    logic [READING_W-1:0] snap     [NUM_SENSORS];
    logic [ACC_W-1:0]     acc      [NUM_SENSORS];
    logic [READING_W-1:0] baseline [NUM_SENSORS];
    logic [CNT_W-1:0]     cnt      [NUM_SENSORS];

    // Evaluation stage: the sensor compared in one cycle is debounced on the next edge.
    logic                 s1_valid;
    logic [IDX_W-1:0]     s1_idx;
    logic                 s1_raw;

    logic [READING_W-1:0] cur_read;
    logic [ACC_W-1:0]     acc_next;
    logic                 raw_now;
    logic                 flip;
    logic                 recal_req;

    always_comb begin
        cur_read  = snap[idx];
        acc_next  = acc[idx] + {{CAL_LOG2{1'b0}}, cur_read};
        raw_now   = {1'b0, cur_read} > ({1'b0, baseline[idx]} + THRESH_X);
        flip      = s1_valid && (s1_raw != touch_mask[s1_idx]) && (cnt[s1_idx] == CNT_LAST);
        recal_req = recalibrate || recal_pend;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= CAL_IDLE;
            idx        <= '0;
            cal_sweep  <= '0;
            recal_pend <= 1'b0;
            busy       <= 1'b0;
            calibrated <= 1'b0;
            touch_mask <= '0;
            s1_valid   <= 1'b0;
            s1_idx     <= '0;
            s1_raw     <= 1'b0;
            // NOTE: per-sensor arrays are reset because a restarted calibration must not see stale sums.
            for (int i = 0; i < NUM_SENSORS; i++) begin
                snap[i]     <= '0;
                acc[i]      <= '0;
                baseline[i] <= '0;
                cnt[i]      <= '0;
            end
        end else begin
            s1_valid <= 1'b0;

            if (s1_valid) begin
                if (s1_raw == touch_mask[s1_idx]) begin
                    cnt[s1_idx] <= '0;
                end else if (cnt[s1_idx] == CNT_LAST) begin
                    touch_mask[s1_idx] <= s1_raw;
                    cnt[s1_idx]        <= '0;
                end else begin
                    cnt[s1_idx] <= cnt[s1_idx] + CNT_W'(1);
                end
            end

            case (state)
                CAL_IDLE, IDLE: begin
                    if (recal_req) begin
                        // NOTE: recalibration waits for the last debounce update of the sweep to retire.
                        if (!s1_valid) begin
                            state      <= CAL_IDLE;
                            recal_pend <= 1'b0;
                            cal_sweep  <= '0;
                            calibrated <= 1'b0;
                            touch_mask <= '0;
                            for (int i = 0; i < NUM_SENSORS; i++) begin
                                acc[i] <= '0;
                                cnt[i] <= '0;
                            end
                        end else begin
                            recal_pend <= 1'b1;
                        end
                    end else if (readings_valid) begin
                        for (int i = 0; i < NUM_SENSORS; i++)
                            snap[i] <= readings[i*READING_W +: READING_W];
                        state <= (state == IDLE) ? SCAN : CAL_SCAN;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end

                CAL_SCAN: begin
                    if (recalibrate)
                        recal_pend <= 1'b1;
                    acc[idx] <= acc_next;
                    if (cal_sweep == LAST_SWEEP)
                        baseline[idx] <= acc_next[CAL_LOG2 +: READING_W];
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        busy      <= 1'b0;
                        cal_sweep <= cal_sweep + SWP_W'(1);
                        if (cal_sweep == LAST_SWEEP) begin
                            calibrated <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= CAL_IDLE;
                        end
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end

                SCAN: begin
                    if (recalibrate)
                        recal_pend <= 1'b1;
                    s1_valid <= 1'b1;
                    s1_idx   <= idx;
                    s1_raw   <= raw_now;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end

                default: state <= CAL_IDLE;
            endcase
        end
    end

    logic [IDX_W-1:0] q_sensor [EVQ_DEPTH];
    logic             q_press  [EVQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             q_empty;
    logic             q_full;
    logic             pop;
    logic             do_push;

    always_comb begin
        q_empty = (wr_ptr == rd_ptr);
        q_full  = (wr_ptr[Q_W] != rd_ptr[Q_W]) && (wr_ptr[Q_W-1:0] == rd_ptr[Q_W-1:0]);
        pop     = event_ack && !q_empty;
        // A pop in the same cycle frees the slot, so a push into a full queue still lands.
        do_push = flip && (!q_full || pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < EVQ_DEPTH; i++) begin
                q_sensor[i] <= '0;
                q_press[i]  <= 1'b0;
            end
        end else begin
            if (do_push) begin
                q_sensor[wr_ptr[Q_W-1:0]] <= s1_idx;
                q_press[wr_ptr[Q_W-1:0]]  <= s1_raw;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (flip && !do_push)
                overflow <= 1'b1;
        end
    end

    assign event_valid  = !q_empty;
    assign event_sensor = q_sensor[rd_ptr[Q_W-1:0]];
    assign event_press  = q_press[rd_ptr[Q_W-1:0]];

endmodule

// File: tb/tb_touch_event_decoder.sv
// Directed bench for touch_event_decoder: calibration, debounce, FIFO ordering/overflow,
// mid-sweep reset, latched recalibration and 33-bit threshold saturation.
module tb_touch_event_decoder;

    logic         clock;
    logic         reset;
    logic [287:0] readings;
    logic         readings_valid;
    logic         recalibrate;
    logic         event_ack;
    logic         event_valid;
    logic [3:0]   event_sensor;
    logic         event_press;
    logic [8:0]   touch_mask;
    logic         calibrated;
    logic         overflow;
    logic         busy;

    int total = 0;
    int bad   = 0;

    touch_event_decoder dut (
        .clock          (clock),
        .reset          (reset),
        .readings       (readings),
        .readings_valid (readings_valid),
        .recalibrate    (recalibrate),
        .event_ack      (event_ack),
        .event_valid    (event_valid),
        .event_sensor   (event_sensor),
        .event_press    (event_press),
        .touch_mask     (touch_mask),
        .calibrated     (calibrated),
        .overflow       (overflow),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Called on a negedge; returns on the negedge just after the capture edge.
    task automatic start_sweep(input logic [31:0] base, input logic [8:0] sel, input logic [31:0] v);
        for (int i = 0; i < 9; i++)
            readings[i*32 +: 32] = sel[i] ? v : base;
        readings_valid = 1'b1;
        @(negedge clock);
        readings_valid = 1'b0;
    endtask

    task automatic run_sweep(input logic [31:0] base, input logic [8:0] sel, input logic [31:0] v);
        start_sweep(base, sel, v);
        repeat (10) @(negedge clock);
    endtask

    task automatic pop_event;
        event_ack = 1'b1;
        @(negedge clock);
        event_ack = 1'b0;
    endtask

    task automatic test_reset;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", event_valid); end
        total++; if (touch_mask !== 9'h000) begin bad++; $display("FAIL rst_mask: got %0h want 0", touch_mask); end
        total++; if (calibrated !== 1'b0) begin bad++; $display("FAIL rst_cal: got %0b want 0", calibrated); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %0b want 0", overflow); end
    endtask

    task automatic test_calib;
        start_sweep(32'd5000, 9'h000, 32'd0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_start: got %0b want 1", busy); end
        repeat (8) @(negedge clock);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_last: got %0b want 1", busy); end
        @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_end: got %0b want 0", busy); end
        @(negedge clock);
        total++; if (calibrated !== 1'b0) begin bad++; $display("FAIL cal_s1: got %0b want 0", calibrated); end

        // A set arriving mid-sweep must be dropped, otherwise baselines would shift.
        start_sweep(32'd5004, 9'h000, 32'd0);
        repeat (3) @(negedge clock);
        readings = {9{32'd90000}};
        readings_valid = 1'b1;
        @(negedge clock);
        readings_valid = 1'b0;
        repeat (6) @(negedge clock);

        run_sweep(32'd4996, 9'h000, 32'd0);
        total++; if (calibrated !== 1'b0) begin bad++; $display("FAIL cal_s3: got %0b want 0", calibrated); end
        run_sweep(32'd5000, 9'h000, 32'd0);
        total++; if (calibrated !== 1'b1) begin bad++; $display("FAIL cal_s4: got %0b want 1", calibrated); end
        total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL cal_noev: got %0b want 0", event_valid); end
    endtask

    task automatic test_press_release;
        repeat (3) run_sweep(32'd5000, 9'h008, 32'd6000);
        total++; if (touch_mask !== 9'h000) begin bad++; $display("FAIL thr_6000: mask %0h want 0", touch_mask); end
        total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL thr_6000_ev: got %0b want 0", event_valid); end

        repeat (2) run_sweep(32'd5000, 9'h008, 32'd6001);
        total++; if (touch_mask !== 9'h000) begin bad++; $display("FAIL press_2: mask %0h want 0", touch_mask); end
        run_sweep(32'd5000, 9'h008, 32'd6001);
        total++; if (touch_mask !== 9'h008) begin bad++; $display("FAIL press_mask: mask %0h want 8", touch_mask); end
        total++; if (event_valid !== 1'b1) begin bad++; $display("FAIL press_valid: got %0b want 1", event_valid); end
        total++; if (event_sensor !== 4'd3) begin bad++; $display("FAIL press_idx: got %0d want 3", event_sensor); end
        total++; if (event_press !== 1'b1) begin bad++; $display("FAIL press_kind: got %0b want 1", event_press); end
        pop_event();
        total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL press_pop: got %0b want 0", event_valid); end

        repeat (2) run_sweep(32'd5000, 9'h000, 32'd0);
        total++; if (touch_mask !== 9'h008) begin bad++; $display("FAIL rel_2: mask %0h want 8", touch_mask); end
        run_sweep(32'd5000, 9'h000, 32'd0);
        total++; if (touch_mask !== 9'h000) begin bad++; $display("FAIL rel_mask: mask %0h want 0", touch_mask); end
        total++; if (event_sensor !== 4'd3) begin bad++; $display("FAIL rel_idx: got %0d want 3", event_sensor); end
        total++; if (event_press !== 1'b0) begin bad++; $display("FAIL rel_kind: got %0b want 0", event_press); end
        pop_event();
    endtask

    task automatic test_glitch;
        repeat (2) run_sweep(32'd5000, 9'h020, 32'd7000);
        run_sweep(32'd5000, 9'h000, 32'd0);
        total++; if (touch_mask !== 9'h000) begin bad++; $display("FAIL glitch_mask: mask %0h want 0", touch_mask); end
        total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL glitch_ev: got %0b want 0", event_valid); end
        // Two more touched sweeps only stay silent if the counter really went back to zero.
        repeat (2) run_sweep(32'd5000, 9'h020, 32'd7000);
        total++; if (touch_mask !== 9'h000) begin bad++; $display("FAIL glitch_cnt: mask %0h want 0", touch_mask); end
        run_sweep(32'd5000, 9'h000, 32'd0);
    endtask

    task automatic test_overflow;
        repeat (2) run_sweep(32'd5000, 9'h01F, 32'd7000);
        total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL ovf_pre: got %0b want 0", event_valid); end
        run_sweep(32'd5000, 9'h01F, 32'd7000);
        total++; if (touch_mask !== 9'h01F) begin bad++; $display("FAIL ovf_mask: mask %0h want 1f", touch_mask); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (event_valid !== 1'b1 || event_sensor !== 4'(k) || event_press !== 1'b1) begin
                bad++;
                $display("FAIL ovf_order%0d: valid=%0b idx=%0d press=%0b want 1/%0d/1",
                         k, event_valid, event_sensor, event_press, k);
            end
            pop_event();
        end
        total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain: got %0b want 0", event_valid); end
    endtask

    task automatic test_reset_mid_sweep;
        start_sweep(32'd5000, 9'h000, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || touch_mask !== 9'h000 || overflow !== 1'b0 ||
            calibrated !== 1'b0 || event_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: busy=%0b mask=%0h ovf=%0b cal=%0b valid=%0b want all 0",
                     busy, touch_mask, overflow, calibrated, event_valid);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        repeat (3) run_sweep(32'd5000, 9'h000, 32'd0);
        total++; if (calibrated !== 1'b0) begin bad++; $display("FAIL recal_s3: got %0b want 0", calibrated); end
        run_sweep(32'd5000, 9'h000, 32'd0);
        total++; if (calibrated !== 1'b1) begin bad++; $display("FAIL recal_s4: got %0b want 1", calibrated); end
    endtask

    task automatic test_full_push_ack;
        repeat (3) run_sweep(32'd5000, 9'h00F, 32'd7000);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_ovf0: got %0b want 0", overflow); end
        repeat (2) run_sweep(32'd5000, 9'h01F, 32'd7000);
        // Sensor 4 pushes at the sixth edge after capture; ack lands on that same edge.
        start_sweep(32'd5000, 9'h01F, 32'd7000);
        repeat (5) @(negedge clock);
        event_ack = 1'b1;
        @(negedge clock);
        event_ack = 1'b0;
        repeat (4) @(negedge clock);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_ack_ovf: got %0b want 0", overflow); end
        total++; if (touch_mask !== 9'h01F) begin bad++; $display("FAIL full_ack_mask: mask %0h want 1f", touch_mask); end
        for (int k = 1; k < 5; k++) begin
            total++;
            if (event_valid !== 1'b1 || event_sensor !== 4'(k)) begin
                bad++;
                $display("FAIL full_ack_order%0d: valid=%0b idx=%0d want 1/%0d", k, event_valid, event_sensor, k);
            end
            pop_event();
        end
        total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL full_ack_drain: got %0b want 0", event_valid); end
    endtask

    task automatic test_latched_recal;
        start_sweep(32'd5000, 9'h000, 32'd0);
        recalibrate = 1'b1;
        @(negedge clock);
        recalibrate = 1'b0;
        repeat (10) @(negedge clock);
        total++; if (calibrated !== 1'b0) begin bad++; $display("FAIL lrecal_cal: got %0b want 0", calibrated); end
        total++; if (touch_mask !== 9'h000) begin bad++; $display("FAIL lrecal_mask: mask %0h want 0", touch_mask); end
        total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL lrecal_ev: got %0b want 0", event_valid); end
    endtask

    task automatic test_saturation;
        repeat (4) run_sweep(32'hFFFF_FF00, 9'h000, 32'd0);
        total++; if (calibrated !== 1'b1) begin bad++; $display("FAIL sat_cal: got %0b want 1", calibrated); end
        repeat (3) run_sweep(32'hFFFF_FF00, 9'h001, 32'hFFFF_FFFF);
        total++; if (touch_mask !== 9'h000) begin bad++; $display("FAIL sat_mask: mask %0h want 0", touch_mask); end
        total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL sat_ev: got %0b want 0", event_valid); end
    endtask

    initial begin
        reset          = 1'b0;
        readings       = '0;
        readings_valid = 1'b0;
        recalibrate    = 1'b0;
        event_ack      = 1'b0;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b1;
        @(negedge clock);
        test_reset();

        test_calib();
        test_press_release();
        test_glitch();
        test_overflow();
        test_reset_mid_sweep();
        test_full_push_ack();
        test_latched_recal();
        test_saturation();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
